// File: rtl/serial_add_controller.sv
// Bit-serial adder sequencer: one full-adder cell, LSB first,
// one bit per clock, registered sum/carry/overflow on completion.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));
endmodule

module serial_add_controller #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             carryIn,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carryOut,
  output logic             overflow
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] sh_a, sh_b, sh_s;
  logic             carry_reg, prev_carry;
  logic [CNT_W-1:0] bit_cnt;
  logic             add_s, add_c;
  logic             last_bit;

  full_adder u_fa (
    .a    (sh_a[0]),
    .b    (sh_b[0]),
    .cin  (carry_reg),
    .s    (add_s),
    .cout (add_c)
  );

  assign last_bit = (bit_cnt == CNT_W'(WIDTH - 1));
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

  always_ff @(posedge clk) begin
    if (!resetN) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last_bit) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetN) begin
      sh_a       <= '0;
      sh_b       <= '0;
      sh_s       <= '0;
      carry_reg  <= 1'b0;
      prev_carry <= 1'b0;
      bit_cnt    <= '0;
      sum        <= '0;
      carryOut   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            sh_a      <= A;
            sh_b      <= B;
            carry_reg <= carryIn;
            bit_cnt   <= '0;
          end
        end
        RUN: begin
          sh_s       <= {add_s, sh_s[WIDTH-1:1]};
          sh_a       <= sh_a >> 1;
          sh_b       <= sh_b >> 1;
          prev_carry <= carry_reg;
          carry_reg  <= add_c;
          bit_cnt    <= bit_cnt + 1'b1;
        end
        DONE: begin
          // prev_carry is the carry into the MSB
          sum      <= sh_s;
          carryOut <= carry_reg;
          overflow <= carry_reg ^ prev_carry;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_add_controller.sv
// Bench for serial_add_controller: vector table, random ops vs
// an arithmetic model, and multi-cycle corner sequences.
module tb_serial_add_controller;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         resetN;
  logic         start;
  logic [W-1:0] A, B;
  logic         carryIn;
  logic         busy, done;
  logic [W-1:0] sum;
  logic         carryOut, overflow;

  int total = 0;
  int bad   = 0;
  logic [W-1:0] last_sum = '0;

  serial_add_controller #(.WIDTH(W), .CNT_W(4)) dut (
    .clk      (clk),
    .resetN   (resetN),
    .start    (start),
    .A        (A),
    .B        (B),
    .carryIn  (carryIn),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .carryOut (carryOut),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic void model(input logic [W-1:0] a, b,
                                input logic ci,
                                output logic [W-1:0] s,
                                output logic co, ov);
    int u, sg;
    u  = int'(a) + int'(b) + int'(ci);
    sg = int'($signed(a)) + int'($signed(b)) + int'(ci);
    s  = u[W-1:0];
    co = (u >= (1 << W));
    ov = (sg > (1 << (W-1)) - 1) || (sg < -(1 << (W-1)));
  endfunction

  // disturb >= 0: at that RUN cycle, change operands and pulse start
  task automatic op(input logic [W-1:0] a, b, input logic ci,
                    input logic [W-1:0] es, input logic eco, eov,
                    input int disturb);
    int n, dn, done_at, cyc;
    logic held_ok;
    @(negedge clk);
    A = a; B = b; carryIn = ci; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0; dn = 0; done_at = -1; cyc = 0; held_ok = 1'b1;
    while (busy && cyc < 40) begin
      if (done) begin
        dn++;
        if (done_at < 0) done_at = cyc;
      end
      if (sum !== last_sum) held_ok = 1'b0;
      n++;
      if (cyc == disturb) begin
        A = 8'hAA; B = 8'h55; carryIn = ~ci; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    check("busy_cycles", n, W + 1);
    check("done_count", dn, 1);
    check("done_pos", done_at, W);
    check("hold_during_run", int'(held_ok), 1);
    check("sum", int'(sum), int'(es));
    check("carryOut", int'(carryOut), int'(eco));
    check("overflow", int'(overflow), int'(eov));
    last_sum = es;
  endtask

  initial begin
    logic [W-1:0] ra, rb, es;
    logic rc, eco, eov;
    int accepts[$];
    int dcnt, multi, gap_bad, cnt;
    logic pb, pd;

    tbl[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1};
    tbl[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
    tbl[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
    tbl[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
    tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};

    resetN = 1'b0; start = 1'b0; A = '0; B = '0; carryIn = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_sum", int'(sum), 0);
    check("rst_co", int'(carryOut), 0);
    check("rst_ov", int'(overflow), 0);
    resetN = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++)
      op(tbl[i].a, tbl[i].b, tbl[i].ci,
         tbl[i].s, tbl[i].co, tbl[i].ov, -1);

    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      model(ra, rb, rc, es, eco, eov);
      op(ra, rb, rc, es, eco, eov, -1);
    end

    // operands and start changed mid-run must not matter
    model(8'h12, 8'h34, 1'b0, es, eco, eov);
    op(8'h12, 8'h34, 1'b0, es, eco, eov, 3);
    model(8'hC3, 8'h9E, 1'b1, es, eco, eov);
    op(8'hC3, 8'h9E, 1'b1, es, eco, eov, W);

    // start held high: one accept every W+2 cycles
    @(negedge clk);
    A = 8'h01; B = 8'h02; carryIn = 1'b0; start = 1'b1;
    pb = 1'b0; pd = 1'b0; dcnt = 0; multi = 0;
    for (int c = 0; c < 45; c++) begin
      @(negedge clk);
      if (busy && !pb) accepts.push_back(c);
      if (done) dcnt++;
      if (done && pd) multi++;
      pb = busy; pd = done;
    end
    start = 1'b0;
    cnt = 0;
    while (busy && cnt < 20) begin
      @(negedge clk);
      cnt++;
    end
    check("held_idle_reached", int'(busy), 0);
    check("held_accepts", int'(accepts.size() >= 4), 1);
    gap_bad = 0;
    for (int i = 1; i < accepts.size(); i++)
      if (accepts[i] - accepts[i-1] != W + 2) gap_bad++;
    check("held_gap", gap_bad, 0);
    check("held_done_width", multi, 0);
    check("held_done_count", int'(dcnt >= accepts.size() - 1), 1);
    check("held_sum", int'(sum), 3);
    last_sum = 8'h03;

    // reset at RUN bit 4 discards the operation
    @(negedge clk);
    A = 8'hFF; B = 8'h01; carryIn = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    resetN = 1'b0;
    @(negedge clk);
    resetN = 1'b1;
    check("abort_busy", int'(busy), 0);
    check("abort_done", int'(done), 0);
    check("abort_sum", int'(sum), 0);
    check("abort_co", int'(carryOut), 0);
    check("abort_ov", int'(overflow), 0);
    dcnt = 0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) dcnt++;
    end
    check("abort_no_done", dcnt, 0);
    last_sum = '0;
    op(8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 1'b0, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
